// File: rtl/coin_in_cond.sv
// coin_in_cond: coin input conditioner for the vending machine front end.
//
// Each raw coin input is synchronised, debounced (a new level must hold for
// DEB_CYCLES synced cycles), and its rising edge becomes a coin event. Events
// are arbitrated onto a single one-cycle coin code for the vending FSM. A
// saturating running total (in 0.5-yuan units) is also kept.
//
// Ports
//   Clk         in   system clock, rising edge
//   Reset       in   asynchronous active-low reset
//   Coin_half   in   raw async 0.5-yuan sensor, active-high
//   Coin_one    in   raw async 1-yuan sensor, active-high
//   Clr_total   in   synchronous clear of Coin_total, active-high
//   D_out       out  one-cycle coin code: 00 none, 01 half, 10 one
//   Coin_total  out  running total in 0.5-yuan units, saturates at 255
module coin_in_cond #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Coin_half,
  input  logic       Coin_one,
  input  logic       Clr_total,
  output logic [1:0] D_out,
  output logic [7:0] Coin_total
);

  localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_HALF = 2'b01;
  localparam logic [1:0] CODE_ONE  = 2'b10;

  // Channel index 0 is the half-yuan input, index 1 the one-yuan input.
  logic [1:0] raw;
  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] stable_p2;
  logic [1:0] evt_p2;
  logic [7:0] cnt_p2 [2];

  logic       pend_half;
  logic       pend_one;
  logic [1:0] d_next;
  logic       pend_half_next;
  logic       pend_one_next;

  assign raw = {Coin_one, Coin_half};

  // The code value equals the number of 0.5-yuan units it represents.
  function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [1:0] code);
    logic [8:0] sum;
    sum = {1'b0, acc} + {7'd0, code};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce and rising-edge event
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stable_p2 <= 2'b00;
      evt_p2    <= 2'b00;
      for (int i = 0; i < 2; i++) cnt_p2[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          cnt_p2[i] <= 8'd0;
        end else if (cnt_p2[i] == DEB_LAST) begin
          stable_p2[i] <= sync_p1[i];
          cnt_p2[i]    <= 8'd0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + 8'd1;
        end
        // Event fires on the same edge the stable level rises.
        evt_p2[i] <= (sync_p1[i] != stable_p2[i]) && (cnt_p2[i] == DEB_LAST) && sync_p1[i];
      end
    end
  end

  // Arbitration: a pending half beats everything; otherwise one-yuan work
  // (pending or new) goes before a new half, which is then parked. Per-channel
  // events are at least 2*DEB_CYCLES cycles apart, so one flag each suffices.
  always_comb begin
    d_next         = CODE_NONE;
    pend_half_next = 1'b0;
    pend_one_next  = 1'b0;
    if (pend_half) begin
      d_next         = CODE_HALF;
      pend_half_next = evt_p2[0];
      pend_one_next  = pend_one | evt_p2[1];
    end else if (pend_one || evt_p2[1]) begin
      d_next         = CODE_ONE;
      pend_one_next  = pend_one & evt_p2[1];
      pend_half_next = evt_p2[0];
    end else if (evt_p2[0]) begin
      d_next = CODE_HALF;
    end
  end

  // Stage p3: coin code output and pending flags
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      D_out     <= CODE_NONE;
      pend_half <= 1'b0;
      pend_one  <= 1'b0;
    end else begin
      D_out     <= d_next;
      pend_half <= pend_half_next;
      pend_one  <= pend_one_next;
    end
  end

  // Stage p4: running total; a clear still keeps the coin shown this cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Coin_total <= 8'd0;
    end else if (Clr_total) begin
      Coin_total <= {6'd0, D_out};
    end else begin
      Coin_total <= sat_add(Coin_total, D_out);
    end
  end

endmodule

// File: tb/tb_coin_in_cond.sv
module tb_coin_in_cond;
  localparam int DEB = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Coin_half = 1'b0;
  logic       Coin_one = 1'b0;
  logic       Clr_total = 1'b0;
  logic [1:0] D_out;
  logic [7:0] Coin_total;

  int errors = 0;
  int checks = 0;

  coin_in_cond #(.DEB_CYCLES(DEB)) dut (
    .Clk(Clk), .Reset(Reset), .Coin_half(Coin_half), .Coin_one(Coin_one),
    .Clr_total(Clr_total), .D_out(D_out), .Coin_total(Coin_total)
  );

  always #5 Clk = ~Clk;

  // Reference model: sampled-input delay line, a window of the last DEB
  // synced samples per channel, and a FIFO of coin values in arrival order.
  logic [1:0] m_s0, m_s1, m_st;
  int m_hist [2][DEB];
  int m_q[$];
  int m_dout;
  int m_total;

  task automatic model_reset();
    m_s0 = 2'b00; m_s1 = 2'b00; m_st = 2'b00;
    for (int c = 0; c < 2; c++) for (int j = 0; j < DEB; j++) m_hist[c][j] = 0;
    m_q.delete();
    m_dout = 0;
    m_total = 0;
  endtask

  task automatic model_edge();
    int v;
    int ch;
    bit all_diff;
    logic [1:0] sv;
    v = m_dout;
    if (Clr_total) m_total = v;
    else m_total = (m_total + v > 255) ? 255 : m_total + v;
    m_dout = (m_q.size() > 0) ? m_q.pop_front() : 0;
    sv = m_s1;
    for (int k = 0; k < 2; k++) begin
      ch = 1 - k; // one-yuan first: simultaneous arrivals queue 1 yuan before 0.5
      for (int j = 0; j < DEB - 1; j++) m_hist[ch][j] = m_hist[ch][j + 1];
      m_hist[ch][DEB - 1] = int'(sv[ch]);
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) if (m_hist[ch][j] == int'(m_st[ch])) all_diff = 1'b0;
      if (all_diff) begin
        m_st[ch] = sv[ch];
        if (sv[ch]) m_q.push_back(ch == 1 ? 2 : 1);
      end
    end
    m_s1 = m_s0;
    m_s0 = {Coin_one, Coin_half};
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Reset) model_edge();
    else model_reset();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Coin_half = 1'b0; Coin_one = 1'b0; Clr_total = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    Coin_one = 1'b1;
    Coin_half = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (D_out !== 2'b00) begin errors++; $display("FAIL reset_dout: got %0d expected 0", D_out); end
      checks++;
      if (Coin_total !== 8'd0) begin errors++; $display("FAIL reset_total: got %0d expected 0", Coin_total); end
    end
    Coin_one = 1'b0;
    Coin_half = 1'b0;
    Reset = 1'b1;
  endtask

  task automatic test_one_hold();
    int pulses, first_k, code;
    do_reset();
    pulses = 0; first_k = -1; code = 0;
    for (int k = 1; k <= 40; k++) begin
      Coin_one = (k <= 20);
      tick();
      checks++;
      if (D_out !== 2'(m_dout)) begin errors++; $display("FAIL one_hold_dout k=%0d: got %0d expected %0d", k, D_out, m_dout); end
      checks++;
      if (Coin_total !== 8'(m_total)) begin errors++; $display("FAIL one_hold_total k=%0d: got %0d expected %0d", k, Coin_total, m_total); end
      if (D_out != 2'b00) begin
        pulses++;
        if (first_k < 0) begin first_k = k; code = int'(D_out); end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL one_hold_pulses: got %0d expected 1", pulses); end
    checks++;
    if (first_k != DEB + 3) begin errors++; $display("FAIL one_hold_latency: got edge %0d expected %0d", first_k, DEB + 3); end
    checks++;
    if (code != 2) begin errors++; $display("FAIL one_hold_code: got %0d expected 2", code); end
    checks++;
    if (Coin_total !== 8'd2) begin errors++; $display("FAIL one_hold_final: got %0d expected 2", Coin_total); end
  endtask

  task automatic test_glitch();
    int pulses;
    do_reset();
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      Coin_half = (k <= 3);
      tick();
      checks++;
      if (D_out !== 2'(m_dout)) begin errors++; $display("FAIL glitch_dout k=%0d: got %0d expected %0d", k, D_out, m_dout); end
      if (D_out != 2'b00) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulses); end
    checks++;
    if (Coin_total !== 8'd0) begin errors++; $display("FAIL glitch_total: got %0d expected 0", Coin_total); end
  endtask

  task automatic test_simultaneous();
    int seq[$];
    int ks[$];
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      Coin_half = (k <= 15);
      Coin_one = (k <= 15);
      tick();
      checks++;
      if (D_out !== 2'(m_dout)) begin errors++; $display("FAIL simul_dout k=%0d: got %0d expected %0d", k, D_out, m_dout); end
      if (D_out != 2'b00) begin seq.push_back(int'(D_out)); ks.push_back(k); end
    end
    checks++;
    if (seq.size() != 2) begin
      errors++; $display("FAIL simul_count: got %0d pulses expected 2", seq.size());
    end else if (seq[0] != 2 || seq[1] != 1 || ks[1] != ks[0] + 1) begin
      errors++; $display("FAIL simul_order: got %0d@%0d,%0d@%0d expected 2 then 1 on next cycle", seq[0], ks[0], seq[1], ks[1]);
    end
    checks++;
    if (Coin_total !== 8'd3) begin errors++; $display("FAIL simul_total: got %0d expected 3", Coin_total); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int p = 0; p < 129; p++) begin
      for (int k = 0; k < 14; k++) begin
        if (p < 127) Coin_one = (k < 6);
        else Coin_half = (k < 6);
        tick();
        checks++;
        if (D_out !== 2'(m_dout) || Coin_total !== 8'(m_total)) begin
          errors++;
          $display("FAIL sat_track p=%0d k=%0d: got %0d/%0d expected %0d/%0d", p, k, D_out, Coin_total, m_dout, m_total);
        end
      end
      if (p == 126) begin
        checks++;
        if (Coin_total !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", Coin_total); end
      end else if (p >= 127) begin
        checks++;
        if (Coin_total !== 8'd255) begin errors++; $display("FAIL sat_255 p=%0d: got %0d expected 255", p, Coin_total); end
      end
    end
  endtask

  task automatic test_clear();
    int codes[5] = '{2, 2, 2, 2, 1};
    bit seen;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 14; k++) begin
        Coin_one = (codes[p] == 2) && (k < 6);
        Coin_half = (codes[p] == 1) && (k < 6);
        tick();
      end
    end
    checks++;
    if (Coin_total !== 8'd9) begin errors++; $display("FAIL clear_pre: got %0d expected 9", Coin_total); end
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      Coin_half = (k < 6);
      Clr_total = (D_out == 2'b01);
      tick();
      checks++;
      if (D_out !== 2'(m_dout) || Coin_total !== 8'(m_total)) begin
        errors++;
        $display("FAIL clear_track k=%0d: got %0d/%0d expected %0d/%0d", k, D_out, Coin_total, m_dout, m_total);
      end
      if (Clr_total) begin
        seen = 1'b1;
        checks++;
        if (Coin_total !== 8'd1) begin errors++; $display("FAIL clear_with_coin: got %0d expected 1", Coin_total); end
      end
      Clr_total = 1'b0;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL clear_pulse_timeout: got no 01 pulse expected one"); end
  endtask

  task automatic test_reset_mid();
    int pulses, first_k;
    // Input released while reset is held: nothing may come out.
    do_reset();
    Coin_half = 1'b1;
    repeat (4) tick();
    Reset = 1'b0;
    model_reset();
    Coin_half = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (D_out != 2'b00) pulses++;
      checks++;
      if (Coin_total !== 8'd0) begin errors++; $display("FAIL rstmid_total k=%0d: got %0d expected 0", k, Coin_total); end
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 0", pulses); end
    // Input still held across reset: exactly one half pulse after release.
    do_reset();
    Coin_half = 1'b1;
    repeat (4) tick();
    Reset = 1'b0;
    model_reset();
    repeat (3) tick();
    Reset = 1'b1;
    pulses = 0; first_k = -1;
    for (int k = 1; k <= 30; k++) begin
      Coin_half = (k <= 20);
      tick();
      checks++;
      if (D_out !== 2'(m_dout)) begin errors++; $display("FAIL rsthold_dout k=%0d: got %0d expected %0d", k, D_out, m_dout); end
      if (D_out == 2'b01) begin pulses++; if (first_k < 0) first_k = k; end
    end
    checks++;
    if (pulses != 1 || first_k != DEB + 3) begin
      errors++; $display("FAIL rsthold_pulse: got %0d pulses at edge %0d expected 1 at edge %0d", pulses, first_k, DEB + 3);
    end
    checks++;
    if (Coin_total !== 8'd1) begin errors++; $display("FAIL rsthold_total: got %0d expected 1", Coin_total); end
  endtask

  task automatic test_random();
    int hold_h, hold_o;
    do_reset();
    hold_h = 0; hold_o = 0;
    for (int c = 0; c < 1200; c++) begin
      if (c < 1000) begin
        if (hold_h == 0) begin Coin_half = 1'($urandom_range(0, 1)); hold_h = $urandom_range(1, 10); end
        if (hold_o == 0) begin Coin_one = 1'($urandom_range(0, 1)); hold_o = $urandom_range(1, 10); end
        hold_h--; hold_o--;
        Clr_total = ($urandom_range(0, 31) == 0);
      end else begin
        Coin_half = 1'b0; Coin_one = 1'b0; Clr_total = 1'b0;
      end
      tick();
      checks++;
      if (D_out !== 2'(m_dout)) begin errors++; $display("FAIL rand_dout c=%0d: got %0d expected %0d", c, D_out, m_dout); end
      checks++;
      if (Coin_total !== 8'(m_total)) begin errors++; $display("FAIL rand_total c=%0d: got %0d expected %0d", c, Coin_total, m_total); end
      checks++;
      if (D_out === 2'b11) begin errors++; $display("FAIL rand_code11 c=%0d: got 3 expected not 3", c); end
    end
    checks++;
    if (m_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d queued coins expected 0", m_q.size()); end
  endtask

  initial begin
    test_reset();
    test_one_hold();
    test_glitch();
    test_simultaneous();
    test_saturation();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
